// File: rtl/muldiv_iter_unit.sv
// Multi-cycle RV64M multiply/divide unit: shift-add multiply, restoring divide, one step per cycle.
// Optional MULDIV_FAST_MUL_EN swaps the multiply loop for a single-cycle combinational multiplier.
module muldiv_iter_unit #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned RD_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic            is_word,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [RD_W-1:0] rd_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [RD_W-1:0] out_rd,
  output logic            busy
);

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  state_t state, state_d;

  logic [XLEN:0]   hi;
  logic [XLEN-1:0] lo, b_q;
  logic [CW-1:0]   cnt;
  logic [1:0]      op_q;
  logic            w_q, neg_q, spec_q;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'(signed'(v));
  endfunction

  // Request decode
  logic            accept, w_in, is_mul_in, sa_op, sb_op, sa, sb, neg_in;
  logic            b_zero, ovf, wmulh, special;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, spec_val;

  assign accept    = in_valid && in_ready && !flush;
  assign w_in      = (XLEN == 64) && is_word;
  assign is_mul_in = !funct3[2];
  assign sa_op     = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign sb_op     = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);

  always_comb begin
    a_ext = rs1_val;
    b_ext = rs2_val;
    if (w_in) begin
      a_ext = sa_op ? sext32(rs1_val[31:0]) : XLEN'(rs1_val[31:0]);
      b_ext = sb_op ? sext32(rs2_val[31:0]) : XLEN'(rs2_val[31:0]);
    end
  end

  assign sa      = sa_op && a_ext[XLEN-1];
  assign sb      = sb_op && b_ext[XLEN-1];
  assign a_mag   = sa ? -a_ext : a_ext;
  assign b_mag   = sb ? -b_ext : b_ext;
  assign neg_in  = (funct3 == 3'b110) ? sa : (sa ^ sb);
  assign b_zero  = (b_ext == '0);
  assign ovf     = funct3[2] && !funct3[0] && (b_ext == '1) &&
                   (a_ext == (w_in ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}}));
  assign wmulh   = w_in && is_mul_in && (funct3[1:0] != 2'b00);
  assign special = wmulh || (funct3[2] && (b_zero || ovf));

  always_comb begin
    spec_val = '0;
    if (wmulh)       spec_val = '0;
    else if (b_zero) spec_val = funct3[1] ? (w_in ? sext32(rs1_val[31:0]) : rs1_val) : '1;
    else if (ovf)    spec_val = funct3[1] ? '0 : a_ext;
  end

  // One iteration of each algorithm
  logic [XLEN:0]   sum, mh, shifted, dh, nh;
  logic [XLEN+1:0] diff;
  logic [XLEN-1:0] ml, dl, nl;
  logic            ge;

  assign sum     = hi + (lo[0] ? {1'b0, b_q} : '0);
  assign mh      = {1'b0, sum[XLEN:1]};
  assign ml      = {sum[0], lo[XLEN-1:1]};
  assign shifted = {hi[XLEN-1:0], lo[XLEN-1]};
  assign diff    = {1'b0, shifted} - {2'b00, b_q};
  assign ge      = !diff[XLEN+1];
  assign dh      = ge ? diff[XLEN:0] : shifted;
  assign dl      = {lo[XLEN-2:0], ge};
  assign nh      = (state == S_MUL) ? mh : dh;
  assign nl      = (state == S_MUL) ? ml : dl;

  logic [XLEN-1:0] prod_hi, prod_lo;
  logic [31:0]     w32;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
  logic [2*XLEN-1:0] fprod;
  assign fprod   = (2*XLEN)'(b_q) * (2*XLEN)'(lo);
  assign prod_hi = fprod[2*XLEN-1:XLEN];
  assign prod_lo = fprod[XLEN-1:0];
  assign w32     = fprod[31:0];
`else
  localparam bit FAST_MUL = 1'b0;
  assign prod_hi = mh[XLEN-1:0];
  assign prod_lo = ml;
  // A 32-step W multiply leaves its low product word at the top of lo
  assign w32     = ml[XLEN-1 -: 32];
`endif

  // Final-step result: sign correction is folded in so no extra cycle is needed
  logic [XLEN-1:0] mul_res, draw, dsg, div_res, result;
  always_comb begin
    if (w_q)                  mul_res = sext32(w32);
    else if (op_q == 2'b00)   mul_res = prod_lo;
    else if (neg_q)           mul_res = ~prod_hi + XLEN'(prod_lo == '0);
    else                      mul_res = prod_hi;
    draw    = op_q[1] ? dh[XLEN-1:0] : dl;
    dsg     = neg_q ? -draw : draw;
    div_res = w_q ? sext32(dsg[31:0]) : dsg;
    result  = spec_q ? lo : ((state == S_MUL) ? mul_res : div_res);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:       if (accept) state_d = is_mul_in ? S_MUL : S_DIV;
      S_MUL, S_DIV: if (cnt == '0) state_d = S_DONE;
      S_DONE:       if (out_ready) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi       <= '0;
      lo       <= '0;
      b_q      <= '0;
      cnt      <= '0;
      op_q     <= '0;
      w_q      <= 1'b0;
      neg_q    <= 1'b0;
      spec_q   <= 1'b0;
      out_data <= '0;
      out_rd   <= '0;
    end else if (accept) begin
      hi     <= '0;
      op_q   <= funct3[1:0];
      w_q    <= w_in;
      neg_q  <= neg_in;
      spec_q <= special;
      out_rd <= rd_in;
      b_q    <= is_mul_in ? a_mag : b_mag;
      if (special)        lo <= spec_val;
      else if (is_mul_in) lo <= b_mag;
      else                lo <= w_in ? (a_mag << (XLEN-32)) : a_mag;
      if (special || (FAST_MUL && is_mul_in)) cnt <= '0;
      else cnt <= w_in ? CW'(31) : CW'(XLEN-1);
    end else if (state == S_MUL || state == S_DIV) begin
      hi  <= nh;
      lo  <= nl;
      cnt <= cnt - 1'b1;
      if (cnt == '0) out_data <= result;
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Scoreboard bench for muldiv_iter_unit (XLEN=64): directed M-extension cases, latency, hold, flush, reset.
module tb_muldiv_iter_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, is_word, flush, out_valid, out_ready, busy;
  logic [2:0]  funct3;
  logic [63:0] rs1_val, rs2_val, out_data;
  logic [4:0]  rd_in, out_rd;

  int n_pass  = 0;
  int n_total = 0;
  logic [68:0] sb_q[$];

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1, MULW_LAT = 1;
`else
  localparam int MUL_LAT = 64, MULW_LAT = 32;
`endif

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  muldiv_iter_unit #(.XLEN(64), .RD_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .is_word(is_word), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .rd_in(rd_in), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] ref_model(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic         ovf;
    ovf = (a == MINV) && (b == ONES);
    case (f3)
      3'b000: begin p = {64'b0, a} * {64'b0, b}; return p[63:0]; end
      3'b001: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
      3'b010: begin p = {{64{a[63]}}, a} * {64'b0, b}; return p[127:64]; end
      3'b011: begin p = {64'b0, a} * {64'b0, b}; return p[127:64]; end
      3'b100: return (b == 0) ? ONES : ovf ? a : 64'($signed(a) / $signed(b));
      3'b101: return (b == 0) ? ONES : a / b;
      3'b110: return (b == 0) ? a : ovf ? 64'd0 : 64'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [2:0] f3, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                        input logic [63:0] exp, input int lat, input int hold);
    int cyc;
    logic [68:0] ent;
    @(negedge clk);
    in_valid = 1'b1; funct3 = f3; is_word = w; rs1_val = a; rs2_val = b; rd_in = rd;
    sb_q.push_back({rd, exp});
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'(lat));
    ent = sb_q.pop_front();
    check({tag, " data"}, out_data, ent[63:0]);
    check({tag, " rd"}, 64'(out_rd), 64'(ent[68:64]));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      check({tag, " hold valid"}, 64'(out_valid), 64'd1);
      check({tag, " hold data"}, out_data, ent[63:0]);
      check({tag, " hold rd"}, 64'(out_rd), 64'(ent[68:64]));
      check({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, " idle after consume"}, 64'({in_ready, out_valid, busy}), 64'b100);
  endtask

  initial begin
    logic seen;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    funct3 = '0; is_word = 1'b0; rs1_val = '0; rs2_val = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", 64'({out_valid, busy}), 64'b00);
    check("reset out_data", out_data, 64'd0);
    check("reset out_rd", 64'(out_rd), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("in_ready after reset", 64'(in_ready), 64'd1);

    run_op("MUL 7*-3",     3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd1, 64'hFFFF_FFFF_FFFF_FFEB, MUL_LAT, 0);
    run_op("MULHU",        3'b011, 1'b0, ONES, 64'd2, 5'd2, 64'd1, MUL_LAT, 0);
    run_op("MULH -1*-1",   3'b001, 1'b0, ONES, ONES, 5'd3, 64'd0, MUL_LAT, 0);
    run_op("MULHSU -1*2",  3'b010, 1'b0, ONES, 64'd2, 5'd4, ONES, MUL_LAT, 0);
    run_op("DIV -7/2",     3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFFD, 64, 0);
    run_op("REM -7/2",     3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd6, ONES, 64, 0);
    run_op("DIVUW",        3'b101, 1'b1, 64'h0000_0000_8000_0000, 64'd1, 5'd7, 64'hFFFF_FFFF_8000_0000, 32, 0);
    run_op("DIVU 5/0",     3'b101, 1'b0, 64'd5, 64'd0, 5'd8, ONES, 1, 0);
    run_op("REM 5/0",      3'b110, 1'b0, 64'd5, 64'd0, 5'd10, 64'd5, 1, 0);
    run_op("DIV ovf",      3'b100, 1'b0, MINV, ONES, 5'd11, MINV, 1, 0);
    run_op("REM ovf",      3'b110, 1'b0, MINV, ONES, 5'd12, 64'd0, 1, 0);
    run_op("MULW",         3'b000, 1'b1, 64'h0000_0001_0000_0003, 64'h0000_0000_FFFF_FFFF, 5'd13, 64'hFFFF_FFFF_FFFF_FFFD, MULW_LAT, 0);
    run_op("MULH W form",  3'b001, 1'b1, 64'd9, 64'd9, 5'd14, 64'd0, 1, 0);
    run_op("REMW -7/2",    3'b110, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd15, ONES, 32, 0);
    run_op("DIVW ovf",     3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd16, 64'hFFFF_FFFF_8000_0000, 1, 0);
    run_op("REMUW by 0",   3'b111, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0000, 5'd17, 64'hFFFF_FFFF_9ABC_DEF0, 1, 0);

    for (int k = 0; k < 6; k++) begin
      logic [2:0]  f3;
      logic [63:0] a, b;
      int          lat;
      f3  = 3'($urandom_range(0, 7));
      a   = {$urandom, $urandom};
      b   = (k % 2 == 0) ? {$urandom, $urandom} : 64'($urandom_range(1, 1000));
      lat = f3[2] ? ((b == 0) ? 1 : 64) : MUL_LAT;
      run_op("random op", f3, 1'b0, a, b, 5'(20 + k), ref_model(f3, a, b), lat, 0);
    end

    run_op("DIVU hold", 3'b101, 1'b0, 64'd100, 64'd7, 5'd9, 64'd14, 64, 10);

    // Flush on the 20th step edge of a divide
    @(negedge clk);
    in_valid = 1'b1; funct3 = 3'b100; is_word = 1'b0; rs1_val = 64'd1000; rs2_val = 64'd3; rd_in = 5'd18;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush to idle", 64'({busy, out_valid, in_ready}), 64'b001);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    check("flushed op no result", 64'(seen), 64'd0);

    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush blocks accept", 64'(busy), 64'd0);
    check("out_data kept after flush", out_data, 64'd14);

    // Reset asserted on the 5th step of a multiply
    @(negedge clk);
    in_valid = 1'b1; funct3 = 3'b011; rs1_val = ONES; rs2_val = ONES; rd_in = 5'd19;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async reset flags", 64'({out_valid, busy}), 64'b00);
    check("async reset out_data", out_data, 64'd0);
    check("async reset out_rd", 64'(out_rd), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no result after reset", 64'({out_valid, busy, in_ready}), 64'b001);

    run_op("DIVU after reset", 3'b101, 1'b0, 64'd1_000_000, 64'd1000, 5'd31, 64'd1000, 64, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
